// File: rtl/lfp_mult_e3m4_fig3_core.sv
// E3M4 x E3M4 -> E4M4 log-domain (Mitchell) multiplier with a single output register.
// Mantissa fractions are added instead of multiplied, so the result never exceeds the exact product.
module lfp_mult_e3m4_fig3_core (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] x1,
    input  logic [7:0] x2,
    output logic [8:0] y,
    output logic       out_valid
);

    logic [4:0] msum;
    logic [3:0] exp_sum;
    logic       is_zero;
    logic [8:0] product;

    // Carry out of the mantissa sum bumps the exponent; 7+7+1 fits in 4 bits, so no saturation.
    always_comb begin
        msum    = {1'b0, x1[3:0]} + {1'b0, x2[3:0]};
        exp_sum = {1'b0, x1[6:4]} + {1'b0, x2[6:4]} + {3'b000, msum[4]};
        is_zero = (x1[6:4] == 3'd0) || (x2[6:4] == 3'd0);
        product = is_zero ? 9'h000 : {x1[7] ^ x2[7], exp_sum, msum[3:0]};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y         <= 9'h000;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                y <= product;
            end
        end
    end

endmodule

// File: tb/tb_lfp_mult_e3m4_fig3_core.sv
// Directed and random checks of the E3M4 Mitchell multiplier: encodings, zero handling,
// reset priority, hold behaviour and the [-0.25, 0] error bound for operands in [1,2).
module tb_lfp_mult_e3m4_fig3_core;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] x1;
    logic [7:0] x2;
    logic [8:0] y;
    logic       out_valid;

    int assertCount;
    int failCount;

    lfp_mult_e3m4_fig3_core dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .x1        (x1),
        .x2        (x2),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive on the falling edge, then sample 1 time unit after the capturing rising edge.
    task automatic applyStimulus(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        rst      = r;
        in_valid = v;
        x1       = a;
        x2       = b;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [8:0] expY, input logic expV);
        assertCount++;
        assert (y === expY) else begin
            failCount++;
            $error("[TB] FAIL %s y: observed %h expected %h", tag, y, expY);
        end
        assertCount++;
        assert (out_valid === expV) else begin
            failCount++;
            $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, out_valid, expV);
        end
    endtask

    // Value of an E4M4 word in units of 1/256 (exact for exponent fields 4..15).
    function automatic int yValue256(input logic [8:0] w);
        int e;
        int mag;
        e = int'(w[7:4]);
        if (e < 4) mag = 0;
        else mag = (16 + int'(w[3:0])) << (e - 4);
        return w[8] ? -mag : mag;
    endfunction

    logic [3:0] m1;
    logic [3:0] m2;
    logic [3:0] pm1;
    logic [3:0] pm2;
    logic       v;
    int         err;

    initial begin
        assertCount = 0;
        failCount   = 0;
        rst = 1'b1; in_valid = 1'b0; x1 = 8'h00; x2 = 8'h00;

        applyStimulus(1'b1, 1'b1, 8'h40, 8'h40);
        checkOutput("reset_with_valid", 9'h000, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h40, 8'h40);
        checkOutput("one_times_one", 9'h080, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h44, 8'h48);
        checkOutput("1p25_times_1p5", 9'h08C, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h48, 8'h48);
        checkOutput("1p5_squared_carry", 9'h090, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hC0, 8'h40);
        checkOutput("negative_one", 9'h180, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h7F, 8'h7F);
        checkOutput("max_exponent", 9'h0FE, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h00, 8'h5A);
        checkOutput("zero_operand", 9'h000, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h80, 8'hC3);
        checkOutput("no_negative_zero", 9'h000, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'hC8, 8'hC8);
        checkOutput("neg_times_neg", 9'h090, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h4F, 8'h41);
        checkOutput("mantissa_wrap", 9'h090, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h3F, 8'h3F);
        checkOutput("small_exponents", 9'h07E, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h44, 8'h48);
        checkOutput("before_hold", 9'h08C, 1'b1);
        applyStimulus(1'b0, 1'b0, 8'h7F, 8'h7F);
        checkOutput("hold_idle", 9'h08C, 1'b0);
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkOutput("hold_idle_2", 9'h08C, 1'b0);
        applyStimulus(1'b1, 1'b1, 8'h7F, 8'h7F);
        checkOutput("reset_discards_pair", 9'h000, 1'b0);
        applyStimulus(1'b0, 1'b1, 8'h48, 8'h48);
        checkOutput("first_after_reset", 9'h090, 1'b1);
        applyStimulus(1'b0, 1'b1, 8'h40, 8'h4C);
        checkOutput("back_to_back", 9'h08C, 1'b1);

        // Random sweep in [1,2): y must under-estimate the exact product by at most 0.25.
        pm1 = 4'h0;
        pm2 = 4'h0;
        for (int i = 0; i < 3000; i++) begin
            m1 = 4'($urandom_range(0, 15));
            m2 = 4'($urandom_range(0, 15));
            v  = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            applyStimulus(1'b0, v, {4'h4, m1}, {4'h4, m2});
            if (v) begin
                pm1 = m1;
                pm2 = m2;
            end
            err = yValue256(y) - (16 + int'(pm1)) * (16 + int'(pm2));
            assertCount++;
            assert (err >= -64 && err <= 0 && y[8] == 1'b0) else begin
                failCount++;
                $error("[TB] FAIL sweep_error m1=%0d m2=%0d: observed y %h err %0d/256 expected err in [-64,0]",
                       pm1, pm2, y, err);
            end
            assertCount++;
            assert (out_valid === v) else begin
                failCount++;
                $error("[TB] FAIL sweep_valid: observed %b expected %b", out_valid, v);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
